alu_rr_arbiter: RTL and testbench

//  Shares one 32-bit ALU between NREQ requesters with round-robin arbitration and valid/ready handshakes.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_rr_arbiter_if.sv | 27 ++
 rtl/alu_rr_arbiter_alu.sv | 28 ++
 rtl/alu_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU arbiter: opcode constants and FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_SUB = 4'b0010;
    localparam logic [3:0] ALUOP_AND = 4'b0100;
    localparam logic [3:0] ALUOP_OR  = 4'b0101;
    localparam logic [3:0] ALUOP_XOR = 4'b0110;
    localparam logic [3:0] ALUOP_NOR = 4'b0111;
    localparam logic [3:0] ALUOP_SLT = 4'b1010;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between NREQ issuing engines and the shared ALU arbiter.
interface alu_rr_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*4-1:0]  req_op;
    logic               resp_valid;
    logic               resp_ready;
    logic [31:0]        resp_result;
    logic               resp_zero;
    logic [IDW-1:0]     resp_id;
    logic [15:0]        op_count;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero, resp_id, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero, resp_id, op_count
    );
endinterface

// File: rtl/alu_rr_arbiter_alu.sv
// Combinational 32-bit ALU datapath; unknown opcodes yield zero.
module alu_rr_arbiter_alu
    import alu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_aluop,
    output logic [31:0] o_result,
    output logic        o_zero
);
    logic [31:0] w_diff;

    always_comb begin
        w_diff   = i_a - i_b;
        o_result = '0;
        case (i_aluop)
            ALUOP_ADD: o_result = i_a + i_b;
            ALUOP_SUB: o_result = w_diff;
            ALUOP_AND: o_result = i_a & i_b;
            ALUOP_OR:  o_result = i_a | i_b;
            ALUOP_XOR: o_result = i_a ^ i_b;
            ALUOP_NOR: o_result = ~(i_a | i_b);
            ALUOP_SLT: o_result = {31'b0, w_diff[31]};
            default:   o_result = '0;
        endcase
        o_zero = (o_result == '0);
    end
endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters; one op in flight, registered response.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input logic              clk,
    input logic              rst_n,
    alu_rr_arbiter_if.slave  bus
);
    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [3:0]      r_op;
    logic [IDW-1:0]  r_id;
    logic            r_resp_valid;
    logic [31:0]     r_resp_result;
    logic            r_resp_zero;
    logic [IDW-1:0]  r_resp_id;
    logic [15:0]     r_op_count;

    logic [NREQ-1:0] w_grant;
    logic            w_fire;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW-1:0]  w_next_ptr;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic [3:0]      w_op;
    logic [31:0]     w_alu_result;
    logic            w_alu_zero;

    // Rotate so ptr sits at bit 0, take the lowest set bit, map it back to the real index.
    function automatic logic [NREQ-1:0] f_rr_grant(input logic [NREQ-1:0] valid,
                                                   input logic [IDW-1:0]  ptr);
        logic [NREQ-1:0] rot;
        logic [NREQ-1:0] gnt;
        logic            found;
        int              idx;
        rot   = '0;
        gnt   = '0;
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            idx    = (int'(ptr) + j) % NREQ;
            rot[j] = valid[idx];
        end
        for (int j = 0; j < NREQ; j++) begin
            if (rot[j] && !found) begin
                found    = 1'b1;
                idx      = (int'(ptr) + j) % NREQ;
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

    always_comb begin
        w_grant  = (r_state == IDLE && rst_n) ? f_rr_grant(bus.req_valid, r_rr_ptr) : '0;
        w_fire   = |w_grant;
        w_gnt_id = '0;
        w_a      = '0;
        w_b      = '0;
        w_op     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_id = IDW'(i);
                w_a      = bus.req_a[32*i +: 32];
                w_b      = bus.req_b[32*i +: 32];
                w_op     = bus.req_op[4*i +: 4];
            end
        end
        w_next_ptr = (int'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;
    end

    alu_rr_arbiter_alu u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_aluop  (r_op),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_id          <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
            r_resp_id     <= '0;
            r_op_count    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_a      <= w_a;
                        r_b      <= w_b;
                        r_op     <= w_op;
                        r_id     <= w_gnt_id;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    r_resp_result <= w_alu_result;
                    r_resp_zero   <= w_alu_zero;
                    r_resp_id     <= r_id;
                    r_resp_valid  <= 1'b1;
                    r_state       <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_op_count   <= r_op_count + 16'd1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = w_grant;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_result = r_resp_result;
    assign bus.resp_zero   = r_resp_zero;
    assign bus.resp_id     = r_resp_id;
    assign bus.op_count    = r_op_count;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed plus randomized bench for alu_rr_arbiter against a transaction-level reference model.
module tb_alu_rr_arbiter;
    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    int          m_ptr = 0;
    logic [15:0] m_count = 16'd0;

    logic [31:0] ta  [NREQ];
    logic [31:0] tbv [NREQ];
    logic [3:0]  top_[NREQ];

    alu_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        case (op)
            4'b0000: return a + b;
            4'b0010: return d;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return a ^ b;
            4'b0111: return ~(a | b);
            4'b1010: return {31'b0, d[31]};
            default: return 32'd0;
        endcase
    endfunction

    // First valid requester at or after the round-robin pointer, wrapping; -1 if none.
    function automatic int m_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32] = ta[i];
            bus.req_b[32*i +: 32] = tbv[i];
            bus.req_op[4*i +: 4]  = top_[i];
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic txn(input logic [NREQ-1:0] vmask, input int stall, input string tag);
        int              g;
        logic [31:0]     er;
        logic [NREQ-1:0] eg;
        drive_ops();
        bus.req_valid  = vmask;
        bus.resp_ready = (stall == 0);
        #1;
        g = m_pick(vmask);
        if (g < 0) begin
            check($sformatf("%s.idle_ready", tag), 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.idle_rv", tag), 32'(bus.resp_valid), 32'd0);
            bus.req_valid = '0;
            return;
        end
        eg    = '0;
        eg[g] = 1'b1;
        er    = m_alu(top_[g], ta[g], tbv[g]);
        check($sformatf("%s.grant", tag), 32'(bus.req_ready), 32'(eg));
        @(posedge clk);
        m_ptr = (g + 1) % NREQ;
        @(negedge clk);
        check($sformatf("%s.exec_rv", tag), 32'(bus.resp_valid), 32'd0);
        // Inputs must be ignored outside IDLE.
        bus.req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32] = $urandom;
            bus.req_b[32*i +: 32] = $urandom;
            bus.req_op[4*i +: 4]  = 4'($urandom_range(0, 15));
        end
        #1;
        check($sformatf("%s.exec_ready", tag), 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s.rv", tag), 32'(bus.resp_valid), 32'd1);
        check($sformatf("%s.result", tag), bus.resp_result, er);
        check($sformatf("%s.zero", tag), 32'(bus.resp_zero), 32'(er == 32'd0));
        check($sformatf("%s.id", tag), 32'(bus.resp_id), 32'(g));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.hold_rv", tag), 32'(bus.resp_valid), 32'd1);
            check($sformatf("%s.hold_res", tag), bus.resp_result, er);
            check($sformatf("%s.hold_ready", tag), 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        m_count = m_count + 16'd1;
        @(negedge clk);
        check($sformatf("%s.done_rv", tag), 32'(bus.resp_valid), 32'd0);
        check($sformatf("%s.count", tag), 32'(bus.op_count), 32'(m_count));
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = 0; tbv[i] = 0; top_[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.rv", 32'(bus.resp_valid), 32'd0);
        check("rst.result", bus.resp_result, 32'd0);
        check("rst.zero", 32'(bus.resp_zero), 32'd0);
        check("rst.id", 32'(bus.resp_id), 32'd0);
        check("rst.count", 32'(bus.op_count), 32'd0);
        check("rst.ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;

        // T1 single add
        ta[0] = 5; tbv[0] = 7; top_[0] = 4'b0000;
        txn(3'b001, 0, "t1");
        check("t1.count_one", 32'(bus.op_count), 32'd1);

        // T2 round robin between req0 (sub 3-3) and req1 (slt 2<5)
        ta[0] = 3; tbv[0] = 3; top_[0] = 4'b0010;
        ta[1] = 2; tbv[1] = 5; top_[1] = 4'b1010;
        for (int n = 0; n < 4; n++) txn(3'b011, 0, $sformatf("t2_%0d", n));

        // T3 backpressure with a competing requester
        ta[0] = 32'hF0F0_0000; tbv[0] = 32'h0F0F_0000; top_[0] = 4'b0110;
        ta[1] = 32'h1;         tbv[1] = 32'h2;         top_[1] = 4'b0000;
        m_ptr = m_ptr;
        txn(3'b001, 4, "t3a");
        txn(3'b011, 4, "t3b");

        // T4 illegal opcode
        ta[2] = 9; tbv[2] = 1; top_[2] = 4'b1111;
        txn(3'b100, 1, "t4");

        // T5 reset during EXEC
        ta[0] = 1; tbv[0] = 2; top_[0] = 4'b0000;
        drive_ops();
        bus.req_valid  = 3'b001;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        m_count = 16'd0;
        m_ptr   = 0;
        check("t5.rv", 32'(bus.resp_valid), 32'd0);
        check("t5.ready", 32'(bus.req_ready), 32'd0);
        check("t5.count", 32'(bus.op_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5.no_resp", 32'(bus.resp_valid), 32'd0);
        ta[1] = 0; tbv[1] = 0; top_[1] = 4'b0111;
        txn(3'b010, 0, "t5_nor");

        // Randomized traffic, including the non-power-of-two pointer wrap
        for (int n = 0; n < 40; n++) begin
            logic [3:0] ops [8];
            ops = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010, 4'b1101};
            for (int i = 0; i < NREQ; i++) begin
                ta[i]   = $urandom;
                tbv[i]  = ($urandom_range(0, 3) == 0) ? ta[i] : $urandom;
                top_[i] = ops[$urandom_range(0, 7)];
            end
            txn(NREQ'($urandom_range(0, (1 << NREQ) - 1)), $urandom_range(0, 3),
                $sformatf("rnd%0d", n));
        end

        // T6 counter wrap from a preloaded near-full value
        force dut.r_op_count = 16'hFFFD;
        @(posedge clk);
        @(negedge clk);
        release dut.r_op_count;
        m_count = 16'hFFFD;
        ta[0] = 4; tbv[0] = 4; top_[0] = 4'b0100;
        for (int n = 0; n < 3; n++) txn(3'b001, 0, $sformatf("t6_%0d", n));
        check("t6.wrapped", 32'(bus.op_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
